// File: rtl/axi_lite_sram_mem_pkg.sv
// Shared encodings for the AXI-Lite SRAM memory: response codes, the channel FSM states and
// the latency-counter width.
package axi_lite_sram_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Latencies are bounded to 1..16, so a counter loaded with LAT-1 fits in 4 bits.
  localparam int unsigned LAT_CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } lat_state_e;

  function automatic logic [1:0] decode_resp(input logic in_range);
    return in_range ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi_lite_sram_mem_lat_counter.sv
// Loadable down-counter used to pace the read and write response channels.
module lat_counter
  import axi_lite_sram_mem_pkg::*;
#(
  parameter int unsigned Width = LAT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Asserted in the cycle whose decrement brings the count to zero.
  assign done_o = (cnt_q <= Width'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_sram_mem.sv
// AXI4-Lite slave memory: one-entry AW/W holds, byte-strobed register array, independent
// read/write FSMs with programmable response latency and out-of-range DECERR.
module axi_lite_sram_mem
  import axi_lite_sram_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return 64'(a >> OFFS_W) < 64'(DEPTH);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- write path
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              aw_full_q, aw_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              w_full_q, w_full_d;
  lat_state_e        w_state_q, w_state_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              commit;
  logic              wr_done;
  logic              w_in_range;
  logic [MEM_AW-1:0] w_idx;

  assign w_in_range = addr_in_range(aw_addr_q);
  assign w_idx      = aw_addr_q[OFFS_W +: MEM_AW];

  assign awready = !aw_full_q;
  assign wready  = !w_full_q;
  assign bvalid  = (w_state_q == StResp);
  assign bresp   = bresp_q;

  always_comb begin
    aw_addr_d = aw_addr_q;
    aw_full_d = aw_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_full_d  = w_full_q;
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;

    if (awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    unique case (w_state_q)
      StIdle: begin
        // Holds that fill while a response is pending commit only once back in idle.
        if (aw_full_q && w_full_q) begin
          commit    = 1'b1;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          bresp_d   = decode_resp(w_in_range);
          w_state_d = (WR_LAT == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (wr_done) w_state_d = StResp;
      end
      StResp: begin
        if (bready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  lat_counter #(
    .Width (LAT_CNT_W)
  ) u_wr_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (commit),
    .load_val_i (LAT_CNT_W'(WR_LAT - 1)),
    .dec_i      (w_state_q == StWait),
    .done_o     (wr_done)
  );

  always_ff @(posedge i_clk) begin
    if (commit && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) mem_q[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  lat_state_e        r_state_q, r_state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ar_hs;
  logic              rd_done;
  logic              ar_in_range;
  logic [MEM_AW-1:0] ar_idx;

  assign ar_in_range = addr_in_range(araddr);
  assign ar_idx      = araddr[OFFS_W +: MEM_AW];
  assign ar_hs       = (r_state_q == StIdle) && arvalid;

  assign arready = (r_state_q == StIdle);
  assign rvalid  = (r_state_q == StResp);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (r_state_q)
      StIdle: begin
        // Sampling the array before the edge gives pre-write data on a same-cycle commit.
        if (arvalid) begin
          rdata_d   = ar_in_range ? mem_q[ar_idx] : '0;
          rresp_d   = decode_resp(ar_in_range);
          r_state_d = (RD_LAT == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (rd_done) r_state_d = StResp;
      end
      StResp: begin
        if (rready) r_state_d = StIdle;
      end
      default: r_state_d = StIdle;
    endcase
  end

  lat_counter #(
    .Width (LAT_CNT_W)
  ) u_rd_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (ar_hs),
    .load_val_i (LAT_CNT_W'(RD_LAT - 1)),
    .dec_i      (r_state_q == StWait),
    .done_o     (rd_done)
  );

  // ----------------------------------------------------------------- state regs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      aw_addr_q <= '0;
      aw_full_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_full_q  <= 1'b0;
      w_state_q <= StIdle;
      bresp_q   <= RESP_OKAY;
      r_state_q <= StIdle;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_addr_q <= aw_addr_d;
      aw_full_q <= aw_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_full_q  <= w_full_d;
      w_state_q <= w_state_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
